muldiv_sequencer: RTL and testbench

- Multi-cycle signed 32-bit multiply/divide unit for the CPU datapath.
- Sequences a radix-2 Booth multiply (one add/sub-shift step per clock) and a non-restoring signed divide, then delivers results on `hi`/`lo` for the HI/LO registers.
- Sits beside the ALU and replaces the combinational multiplier on the critical path.
- A start/busy/done handshake lets the control unit stall while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 47 ++++
 rtl/muldiv_sequencer_if.sv | 37 +++
 rtl/muldiv_step.sv | 87 ++++++++
 rtl/muldiv_sequencer.sv | 160 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multi-cycle multiply/divide sequencer:
//   WIDTH          operand / result width
//   ITER, CNT_W    iteration count and width of the step counter
//   state_e        sequencer states (ST_IDLE .. ST_DONE)
//   step_mode_e    what the shared add/sub-shift step computes this cycle
//   OP_MUL/OP_DIV  encoding of the op input
//   DIV0_QUOTIENT  quotient reported for a zero divisor
//   negate_if / magnitude  two's complement sign helpers
// ----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    STEP_MUL,  // Booth add/sub then arithmetic right shift
    STEP_DIV,  // non-restoring shift-left then add/sub
    STEP_FIX   // add the divisor back if the remainder went negative
  } step_mode_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // -2^31 maps to 32'h8000_0000, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return negate_if(v, v[WIDTH-1]);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer_if
// Request/result bundle between the control unit (master) and the
// multiply/divide sequencer (slave).
//   start        request, sampled only while busy is low
//   op           0 = MUL, 1 = DIV, captured with start
//   opa, opb     signed operands, captured with start
//   busy         operation in flight
//   done         one-cycle pulse; hi/lo valid from this cycle on
//   hi, lo       MUL: product[63:32] / product[31:0]; DIV: remainder / quotient
//   div_by_zero  last DIV had a zero divisor
// ----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
  parameter int WIDTH = muldiv_pkg::WIDTH
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, opa, opb,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/muldiv_step.sv
// ----------------------------------------------------------------------------
// muldiv_step
// Combinational single step shared by multiply and divide; it holds the one
// (WIDTH+1)-bit adder of the unit.
//   mode      STEP_MUL / STEP_DIV / STEP_FIX
//   acc       MUL: sign-extended A; DIV: signed partial remainder
//   q, q_m1   MUL: multiplier and Booth guard bit; DIV: dividend/quotient
//   m         MUL: multiplicand; DIV: divisor magnitude
//   *_nxt     register values after this step
// The extra adder bit keeps the true sign of A when A +/- M overflows 32 bits,
// so the shift is right even for -2^31 * -2^31; for divide it holds the sign of
// the partial remainder.
// ----------------------------------------------------------------------------
module muldiv_step
  import muldiv_pkg::*;
(
  input  step_mode_e       mode,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_m1_nxt
);

  logic [WIDTH:0] add_a;
  logic [WIDTH:0] add_b;
  logic           sub;
  logic [WIDTH:0] sum;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    add_a = acc;
    add_b = '0;
    sub   = 1'b0;
    case (mode)
      STEP_MUL: begin
        case ({q[0], q_m1})
          2'b01:   add_b = {m[WIDTH-1], m};
          2'b10: begin
            add_b = {m[WIDTH-1], m};
            sub   = 1'b1;
          end
          default: add_b = '0;
        endcase
      end
      STEP_DIV: begin
        // Shift the next dividend bit into the remainder; subtract while the
        // remainder is non-negative, add back otherwise.
        add_a = {acc[WIDTH-1:0], q[WIDTH-1]};
        add_b = {1'b0, m};
        sub   = ~acc[WIDTH];
      end
      STEP_FIX: begin
        add_b = acc[WIDTH] ? {1'b0, m} : '0;
      end
      default: begin
        add_b = '0;
      end
    endcase
  end

  assign sum = add_a + (sub ? ~add_b : add_b) + {{WIDTH{1'b0}}, sub};

  always_comb begin
    acc_nxt  = sum;
    q_nxt    = q;
    q_m1_nxt = q_m1;
    case (mode)
      STEP_MUL: begin
        acc_nxt  = {sum[WIDTH], sum[WIDTH:1]};
        q_nxt    = {sum[0], q[WIDTH-1:1]};
        q_m1_nxt = q[0];
      end
      STEP_DIV: begin
        q_nxt    = {q[WIDTH-2:0], ~sum[WIDTH]};
        q_m1_nxt = 1'b0;
      end
      default: begin
        acc_nxt = sum;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle signed multiply (radix-2 Booth) and divide (non-restoring) unit
// delivering HI/LO results to the CPU datapath.
//   clock   rising-edge clock
//   clear   asynchronous active-low reset
//   bus     muldiv_sequencer_if.slave (start/op/opa/opb in,
//           busy/done/hi/lo/div_by_zero out)
// MUL takes 32 step cycles, DIV 32 steps plus one FIX cycle. A zero divisor
// skips the steps and spends its single busy cycle in FIX, where the fixed
// divide-by-zero result is written.
// ----------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  muldiv_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

  state_e           state;
  logic [CNT_W-1:0] count;

  // Operation datapath
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH-1:0] m;
  logic             neg_q;     // quotient negated: operand signs differ
  logic             neg_r;     // remainder negated: dividend negative
  logic             zero_div;  // divisor was zero; q holds the raw dividend

  step_mode_e       step_mode;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             q_m1_nxt;
  logic             accept;

  assign accept = bus.start && (state == ST_IDLE || state == ST_DONE);

  always_comb begin
    step_mode = STEP_MUL;
    if (state == ST_DIV) begin
      step_mode = STEP_DIV;
    end else if (state == ST_FIX) begin
      step_mode = STEP_FIX;
    end
  end

  muldiv_step u_step (
    .mode     (step_mode),
    .acc      (acc),
    .q        (q),
    .q_m1     (q_m1),
    .m        (m),
    .acc_nxt  (acc_nxt),
    .q_nxt    (q_nxt),
    .q_m1_nxt (q_m1_nxt)
  );

  // NOTE: the datapath registers carry no reset: each operation loads all of
  // them at accept before anything reads them, and the FSM never leaves IDLE
  // without an accept.
  always_ff @(posedge clock) begin
    if (accept) begin
      acc   <= '0;
      q_m1  <= 1'b0;
      neg_q <= bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1];
      neg_r <= bus.opa[WIDTH-1];
      if (bus.op == OP_MUL) begin
        m        <= bus.opa;
        q        <= bus.opb;
        zero_div <= 1'b0;
      end else begin
        m        <= magnitude(bus.opb);
        q        <= (bus.opb == '0) ? bus.opa : magnitude(bus.opa);
        zero_div <= (bus.opb == '0);
      end
    end else if (state == ST_MUL || state == ST_DIV) begin
      acc  <= acc_nxt;
      q    <= q_nxt;
      q_m1 <= q_m1_nxt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state           <= ST_IDLE;
      count           <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            count           <= '0;
            bus.div_by_zero <= 1'b0;
            bus.busy        <= 1'b1;
            if (bus.op == OP_MUL) begin
              state <= ST_MUL;
            end else if (bus.opb == '0) begin
              state <= ST_FIX;
            end else begin
              state <= ST_DIV;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_MUL: begin
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            state    <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.hi   <= acc_nxt[WIDTH-1:0];
            bus.lo   <= q_nxt;
          end
        end

        ST_DIV: begin
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            state <= ST_FIX;
          end
        end

        ST_FIX: begin
          state    <= ST_DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          if (zero_div) begin
            bus.hi          <= q;
            bus.lo          <= DIV0_QUOTIENT;
            bus.div_by_zero <= 1'b1;
          end else begin
            // acc_nxt is the restored (non-negative) remainder magnitude.
            bus.hi <= negate_if(acc_nxt[WIDTH-1:0], neg_r);
            bus.lo <= negate_if(q, neg_q);
          end
        end

        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer: directed vector table, random
// operations against a plain-arithmetic reference, and hand-written sequences
// for back-to-back issue and mid-operation reset.
// ----------------------------------------------------------------------------
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clock = 1'b0;
  logic clear;

  always #5 clock = ~clock;

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
    int          elat;
    int          poke;   // cycle of an ignored start pulse, -1 for none
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic; SV division truncates toward
  // zero and the remainder takes the dividend's sign.
  function automatic logic [63:0] ref_model(input logic op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] qv;
    logic [63:0] rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_MUL) return 64'(sa * sb);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    qv = 64'(sa / sb);
    rv = 64'(sa % sb);
    return {rv[31:0], qv[31:0]};
  endfunction

  function automatic int exp_latency(input logic op, input logic [31:0] b);
    if (op == OP_MUL) return 32;
    return (b == 32'd0) ? 1 : 33;
  endfunction

  // Issue one operation from idle and check result, latency, busy length,
  // HI/LO hold while busy, busy low at done, and the one-cycle done pulse.
  task automatic run_and_check(input string tag, input logic op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp_res, input logic exp_dbz,
                               input int exp_lat, input int poke_at);
    logic [31:0] hi0;
    logic [31:0] lo0;
    int          lat;
    int          busy_cnt;
    logic        held;
    @(negedge clock);
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    @(negedge clock);
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.opa   = $urandom;
    bus.opb   = $urandom;
    lat = 0;
    busy_cnt = 0;
    held = 1'b1;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cnt++;
      if (bus.hi !== hi0 || bus.lo !== lo0) held = 1'b0;
      if (lat == poke_at) begin
        bus.start = 1'b1;
        bus.op    = OP_DIV;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clock);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/result"}, {bus.hi, bus.lo}, exp_res);
    check({tag, "/div_by_zero"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, "/busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, "/hold_while_busy"}, 64'(held), 64'd1);
    @(negedge clock);
    check({tag, "/done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog expired");
  end

  int   n;
  logic seen_done;

  initial begin
    logic        rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    vecs.push_back('{OP_MUL, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32, -1});
    vecs.push_back('{OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 32, -1});
    vecs.push_back('{OP_MUL, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32, -1});
    vecs.push_back('{OP_DIV, 32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0, 33, -1});
    vecs.push_back('{OP_DIV, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 33, -1});
    vecs.push_back('{OP_DIV, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1,  -1});
    vecs.push_back('{OP_MUL, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 32, -1});
    vecs.push_back('{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33, -1});
    vecs.push_back('{OP_MUL, 32'h0000_ABCD, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h5433_0000, 1'b0, 32, 10});
    vecs.push_back('{OP_DIV, 32'd3,         32'hFFFF_FFF6, 32'd3,         32'd0,         1'b0, 33, -1});
    vecs.push_back('{OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0, 33, -1});
    vecs.push_back('{OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 32, -1});

    clear     = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.opa   = '0;
    bus.opb   = '0;
    repeat (2) @(negedge clock);
    check("reset/flags", 64'({bus.busy, bus.done, bus.div_by_zero}), 64'd0);
    check("reset/hi", 64'(bus.hi), 64'd0);
    check("reset/lo", 64'(bus.lo), 64'd0);
    clear = 1'b1;

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    {vecs[i].ehi, vecs[i].elo}, vecs[i].edbz, vecs[i].elat,
                    vecs[i].poke);
    end

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) ra = 32'h8000_0000;
      if (sel == 2) rb = $urandom_range(1, 20);
      if (sel == 3) rb = 32'hFFFF_FFFF;
      run_and_check($sformatf("rand%0d", i), rop, ra, rb, ref_model(rop, ra, rb),
                    (rop == OP_DIV) && (rb == 32'd0), exp_latency(rop, rb), -1);
    end

    // Back-to-back: start held high through DONE
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.opa   = 32'd3;
    bus.opb   = 32'd5;
    @(negedge clock);
    bus.op  = OP_DIV;
    bus.opa = 32'd50;
    bus.opb = 32'd7;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("b2b/first_latency", 64'(n), 64'd32);
    check("b2b/first_result", {bus.hi, bus.lo}, 64'd15);
    @(negedge clock);
    bus.start = 1'b0;
    check("b2b/no_idle_cycle", 64'({bus.busy, bus.done}), 64'b10);
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("b2b/second_latency", 64'(n), 64'd33);
    check("b2b/second_result", {bus.hi, bus.lo}, {32'd1, 32'd7});
    @(negedge clock);

    // Reset in the middle of a divide
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.opa   = 32'd1000;
    bus.opb   = 32'd3;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (14) @(negedge clock);
    clear = 1'b0;
    #1;
    check("midreset/flags", 64'({bus.busy, bus.done, bus.div_by_zero}), 64'd0);
    check("midreset/result", {bus.hi, bus.lo}, 64'd0);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (bus.done) seen_done = 1'b1;
    end
    clear = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    check("midreset/abandoned", 64'(seen_done), 64'd0);
    run_and_check("post_reset_mul", OP_MUL, 32'd3, 32'd4, 64'd12, 1'b0, 32, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
